c3lib_ckmux2_sel_ctl: RTL and testbench
=======================================

Name: c3lib_ckmux2_sel_ctl

Overview:
Select sequencer for a 2-to-1 clock-tree mux. It accepts switch requests over a valid/ready handshake and drives the mux select `s0` and a downstream clock-gate enable `ck_gate_en`. The order is always: gate off → quiesce wait → change select → settle wait → gate on. This keeps the combinational mux from passing a runt pulse into the tree. It runs on an always-on control clock and includes a scan/test override path.

Parameters:
QUIESCE_CYC, 4, cycles `ck_gate_en` is held low before `s0` changes; legal range 1 to 2^CNT_WIDTH-1.
SETTLE_CYC, 4, cycles after the `s0` change before `ck_gate_en` reasserts; legal range 1 to 2^CNT_WIDTH-1.
CNT_WIDTH, 4, width of the shared wait counter.

Ports:
clk  input  1  always-on control clock.
rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
req_vld  input  1  switch request valid.
req_sel  input  1  requested select: 0 = ck0, 1 = ck1.
req_rdy  output  1  request ready; transfer occurs when req_vld & req_rdy.
done  output  1  one-cycle pulse when a request completes.
busy  output  1  high while the FSM is not in IDLE.
s0  output  1  select to the mux.
ck_gate_en  output  1  enable to the downstream clock gate.
tst_override  input  1  scan override.
tst_s0  input  1  scan select value.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state = IDLE, internal select register sel_q = 0, gate register = 1, counter = 0, done = 0.
  - Reset mid-sequence aborts the switch and returns to these values on the next edge. No partial state is retained.
- req_rdy = (state==IDLE) & ~tst_override, combinational. busy = (state!=IDLE).
- FSM states: IDLE, GATE_OFF, SETTLE, GATE_ON.
- IDLE:
  - On accept with req_sel==sel_q: stay in IDLE and pulse done on the next cycle. Gate and select are untouched.
  - On accept with req_sel!=sel_q: latch the target, go to GATE_OFF, drive gate = 0, load counter = QUIESCE_CYC-1.
- GATE_OFF:
  - Gate stays 0; counter decrements each cycle.
  - When counter==0: sel_q takes the target, load counter = SETTLE_CYC-1, go to SETTLE.
- SETTLE:
  - Gate stays 0; counter decrements.
  - When counter==0: go to GATE_ON.
- GATE_ON: gate = 1, done = 1 for this one cycle, next state IDLE.
- Registered timeline with defaults, request accepted at edge T:
  - ck_gate_en falls at T+1.
  - s0 changes at T+1+QUIESCE_CYC = T+5.
  - ck_gate_en rises and done pulses at T+1+QUIESCE_CYC+SETTLE_CYC = T+9.
  - req_rdy is high again at T+10.
- Invariant: s0 never changes in a cycle where ck_gate_en=1, and ck_gate_en never rises in the same cycle s0 changes.
- Requests while busy are not accepted (req_rdy=0). req_vld may stay asserted and is accepted once IDLE is reached.
- Counter: no wrap. It is loaded only on state entry and decrements only while nonzero.
- tst_override=1:
  - s0 = tst_s0 and ck_gate_en = 1, combinational bypass. req_rdy = 0.
  - The FSM advances only from IDLE; a sequence already in flight completes internally.
  - sel_q is unchanged. On release, outputs return to sel_q and the gate register value.
- done is never asserted during reset or in two consecutive cycles for a single request.

Test Plan:
1. Reset, then rst_n released; hold for 3 cycles → s0=0, ck_gate_en=1, req_rdy=1, busy=0, done=0.
2. req_vld=1, req_sel=1 accepted at cycle 10 → ck_gate_en=0 at 11; s0=1 at 15; ck_gate_en=1 and done=1 at 19 only; req_rdy=1 at 20.
3. req_sel=0 when s0=0 → done pulses next cycle; ck_gate_en stays 1 throughout; busy stays 0.
4. Assert rst_n=0 at cycle 13 during a 0→1 switch (s0 still 0, gate 0) → next edge s0=0, ck_gate_en=1, state IDLE, no done pulse.
5. Hold req_vld=1 with alternating req_sel back-to-back → each request accepted only when req_rdy=1. Checker confirms s0 never toggles while ck_gate_en=1 over 1000 random cycles.
6. tst_override=1, tst_s0=1 while idle with sel_q=0 → s0=1, ck_gate_en=1, req_rdy=0. Release override → s0=0 on the same cycle.

Source files
------------

// File: rtl/c3lib_ckmux2_sel_ctl.sv
`default_nettype none
// ============================================================================
// Module      : c3lib_ckmux2_sel_ctl
// Description : Select sequencer for a 2:1 clock-tree mux. A switch request
//               arrives over a valid/ready handshake. The block then runs
//               gate-off -> quiesce wait -> select change -> settle wait ->
//               gate-on, so the combinational mux never passes a runt pulse
//               into the tree. A scan override bypasses the select and forces
//               the gate open.
// Ports       : clk          always-on control clock
//               rst_n        synchronous active-low reset
//               req_vld      switch request valid
//               req_sel      requested select (0 = ck0, 1 = ck1)
//               req_rdy      request ready (IDLE and no override)
//               done         one-cycle pulse when a request completes
//               busy         sequencer not in IDLE
//               s0           mux select
//               ck_gate_en   downstream clock-gate enable
//               tst_override scan override
//               tst_s0       scan select value
// Revision    : 1.0 - initial release
// ============================================================================
module c3lib_ckmux2_sel_ctl #(
    parameter int QUIESCE_CYC = 4,
    parameter int SETTLE_CYC  = 4,
    parameter int CNT_WIDTH   = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_vld,
    input  logic req_sel,
    output logic req_rdy,
    output logic done,
    output logic busy,
    output logic s0,
    output logic ck_gate_en,
    input  logic tst_override,
    input  logic tst_s0
);

    // Counter load values: a wait of N cycles counts N-1 down to 0, and the
    // cycle spent recognising zero supplies the final wait cycle.
    localparam logic [CNT_WIDTH-1:0] c_quiesce_load = CNT_WIDTH'(QUIESCE_CYC - 1);
    localparam logic [CNT_WIDTH-1:0] c_settle_load  = CNT_WIDTH'(SETTLE_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_GATE_OFF = 2'd1,
        ST_SETTLE   = 2'd2,
        ST_GATE_ON  = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_sel;
    logic                   w_sel_nxt;
    logic                   r_target;
    logic                   w_target_nxt;
    logic                   r_gate;
    logic                   w_gate_nxt;
    logic                   r_done;
    logic                   w_done_nxt;
    logic [CNT_WIDTH-1:0]   r_cnt;
    logic [CNT_WIDTH-1:0]   w_cnt_nxt;
    logic                   w_accept;
    logic                   w_cnt_zero;

    assign w_accept   = req_vld & req_rdy;
    assign w_cnt_zero = (r_cnt == '0);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_sel    <= 1'b0;
            r_target <= 1'b0;
            r_gate   <= 1'b1;
            r_done   <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_sel    <= w_sel_nxt;
            r_target <= w_target_nxt;
            r_gate   <= w_gate_nxt;
            r_done   <= w_done_nxt;
            r_cnt    <= w_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic. The override only blocks new requests (through
    // req_rdy); a sequence already in flight runs to completion so the
    // internal gate/select registers stay coherent when the override drops.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_sel_nxt    = r_sel;
        w_target_nxt = r_target;
        w_gate_nxt   = r_gate;
        w_done_nxt   = 1'b0;
        w_cnt_nxt    = r_cnt;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (req_sel == r_sel) begin
                        // Already on the requested clock: acknowledge only.
                        w_done_nxt = 1'b1;
                    end else begin
                        w_target_nxt = req_sel;
                        w_gate_nxt   = 1'b0;
                        w_cnt_nxt    = c_quiesce_load;
                        w_state_nxt  = ST_GATE_OFF;
                    end
                end
            end

            ST_GATE_OFF: begin
                if (w_cnt_zero) begin
                    // Gate has been closed for the full quiesce window.
                    w_sel_nxt   = r_target;
                    w_cnt_nxt   = c_settle_load;
                    w_state_nxt = ST_SETTLE;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end

            ST_SETTLE: begin
                if (w_cnt_zero) begin
                    // Reopen the gate and report completion on the same edge.
                    w_gate_nxt  = 1'b1;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = ST_GATE_ON;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end

            ST_GATE_ON: begin
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign req_rdy    = (r_state == ST_IDLE) & ~tst_override;
    assign busy       = (r_state != ST_IDLE);
    assign done       = r_done;
    assign s0         = tst_override ? tst_s0 : r_sel;
    assign ck_gate_en = tst_override | r_gate;

endmodule
`default_nettype wire

// File: tb/tb_c3lib_ckmux2_sel_ctl.sv
`default_nettype none
// ============================================================================
// Module      : tb_c3lib_ckmux2_sel_ctl
// Description : Self-checking bench for c3lib_ckmux2_sel_ctl. A table of
//               per-cycle vectors covers reset, same-select acknowledge, a
//               full 0->1 switch, a 1->0 switch with scan override toggling,
//               and override while idle. Hand sequences cover reset aborts
//               and a long back-to-back request run with glitch-safety
//               invariants and request/done accounting.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_c3lib_ckmux2_sel_ctl;

    logic clk = 1'b0;
    logic rst_n;
    logic req_vld;
    logic req_sel;
    logic req_rdy;
    logic done;
    logic busy;
    logic s0;
    logic ck_gate_en;
    logic tst_override;
    logic tst_s0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    c3lib_ckmux2_sel_ctl #(
        .QUIESCE_CYC (4),
        .SETTLE_CYC  (4),
        .CNT_WIDTH   (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_vld      (req_vld),
        .req_sel      (req_sel),
        .req_rdy      (req_rdy),
        .done         (done),
        .busy         (busy),
        .s0           (s0),
        .ck_gate_en   (ck_gate_en),
        .tst_override (tst_override),
        .tst_s0       (tst_s0)
    );

    // in  = {rst_n, req_vld, req_sel, tst_override, tst_s0}
    // exp = {s0, ck_gate_en, req_rdy, busy, done}, observed before the edge
    typedef struct packed {
        logic [4:0] in;
        logic [4:0] exp;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept a 0->1 switch, let it run for 'w' edges, then reset.
    task automatic abort_at(input int w, input logic exp_s0_before);
        req_vld = 1'b1;
        req_sel = 1'b1;
        #1;
        check($sformatf("abort%0d accept_rdy", w), req_rdy, 1'b1);
        step();
        req_vld = 1'b0;
        repeat (w) step();
        check($sformatf("abort%0d pre_s0", w), s0, exp_s0_before);
        check($sformatf("abort%0d pre_gate", w), ck_gate_en, 1'b0);
        rst_n = 1'b0;
        step();
        check($sformatf("abort%0d s0", w), s0, 1'b0);
        check($sformatf("abort%0d gate", w), ck_gate_en, 1'b1);
        check($sformatf("abort%0d busy", w), busy, 1'b0);
        check($sformatf("abort%0d rdy", w), req_rdy, 1'b1);
        check($sformatf("abort%0d done", w), done, 1'b0);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("abort%0d post%0d done", w, k), done, 1'b0);
            check($sformatf("abort%0d post%0d busy", w, k), busy, 1'b0);
        end
    endtask

    initial begin
        int   acc_cnt;
        int   done_cnt;
        logic last_sel;
        logic want;
        logic acc;
        logic prev_s0;
        logic prev_gate;
        logic prev_busy;

        // Reset then idle
        tbl.push_back({5'b00000, 5'b01100});
        tbl.push_back({5'b10000, 5'b01100});
        tbl.push_back({5'b10000, 5'b01100});
        tbl.push_back({5'b10000, 5'b01100});
        // Same-select request: done next cycle, gate untouched
        tbl.push_back({5'b11000, 5'b01100});
        tbl.push_back({5'b10000, 5'b01101});
        tbl.push_back({5'b10000, 5'b01100});
        // 0->1 switch accepted here (T)
        tbl.push_back({5'b11100, 5'b01100});
        tbl.push_back({5'b10000, 5'b00010});   // T+1 gate off
        tbl.push_back({5'b10000, 5'b00010});
        tbl.push_back({5'b10000, 5'b00010});
        tbl.push_back({5'b10000, 5'b00010});
        tbl.push_back({5'b10000, 5'b10010});   // T+5 s0 changes
        tbl.push_back({5'b10000, 5'b10010});
        tbl.push_back({5'b10000, 5'b10010});
        tbl.push_back({5'b10000, 5'b10010});
        tbl.push_back({5'b10000, 5'b11011});   // T+9 gate on + done
        tbl.push_back({5'b10000, 5'b11100});   // T+10 ready
        // Same-select on ck1
        tbl.push_back({5'b11100, 5'b11100});
        tbl.push_back({5'b10000, 5'b11101});
        // Override while idle: requests refused, select bypassed
        tbl.push_back({5'b11010, 5'b01000});
        tbl.push_back({5'b11011, 5'b11000});
        tbl.push_back({5'b10000, 5'b11100});
        // 1->0 switch with override toggled mid-flight
        tbl.push_back({5'b11000, 5'b11100});
        tbl.push_back({5'b10011, 5'b11010});
        tbl.push_back({5'b10010, 5'b01010});
        tbl.push_back({5'b10000, 5'b10010});
        tbl.push_back({5'b10000, 5'b10010});
        tbl.push_back({5'b10000, 5'b00010});
        tbl.push_back({5'b10011, 5'b11010});
        tbl.push_back({5'b10000, 5'b00010});
        tbl.push_back({5'b10000, 5'b00010});
        tbl.push_back({5'b10000, 5'b01011});
        // Override while idle on ck0, then release
        tbl.push_back({5'b10011, 5'b11000});
        tbl.push_back({5'b10000, 5'b01100});

        rst_n        = 1'b0;
        req_vld      = 1'b0;
        req_sel      = 1'b0;
        tst_override = 1'b0;
        tst_s0       = 1'b0;
        step();

        for (int i = 0; i < tbl.size(); i++) begin
            {rst_n, req_vld, req_sel, tst_override, tst_s0} = tbl[i].in;
            #1;
            check($sformatf("row%0d s0", i),         s0,         tbl[i].exp[4]);
            check($sformatf("row%0d ck_gate_en", i), ck_gate_en, tbl[i].exp[3]);
            check($sformatf("row%0d req_rdy", i),    req_rdy,    tbl[i].exp[2]);
            check($sformatf("row%0d busy", i),       busy,       tbl[i].exp[1]);
            check($sformatf("row%0d done", i),       done,       tbl[i].exp[0]);
            step();
        end

        // Reset aborts: during quiesce (s0 still 0) and just before gate-on
        abort_at(3, 1'b0);
        abort_at(7, 1'b1);

        // Back-to-back requests with req_vld mostly held high
        acc_cnt   = 0;
        done_cnt  = 0;
        last_sel  = s0;
        want      = ~s0;
        prev_s0   = s0;
        prev_gate = ck_gate_en;
        prev_busy = busy;
        for (int c = 0; c < 1000; c++) begin
            req_vld = ($urandom_range(0, 3) != 0);
            req_sel = want;
            #1;
            acc = req_vld & req_rdy;
            step();
            if (done) done_cnt++;
            if (s0 !== prev_s0) begin
                check($sformatf("cyc%0d s0_change_gate_now", c), ck_gate_en, 1'b0);
                check($sformatf("cyc%0d s0_change_gate_prev", c), prev_gate, 1'b0);
            end
            if (ck_gate_en && !prev_gate)
                check($sformatf("cyc%0d gate_rise_s0_stable", c), s0, prev_s0);
            if (busy && !prev_busy)
                check($sformatf("cyc%0d busy_after_accept", c), acc, 1'b1);
            if (acc) begin
                acc_cnt++;
                last_sel = req_sel;
                if ($urandom_range(0, 3) != 0) want = ~want;
            end
            prev_s0   = s0;
            prev_gate = ck_gate_en;
            prev_busy = busy;
        end
        req_vld = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (done) done_cnt++;
        end
        check_int("random done_count", done_cnt, acc_cnt);
        check("random final_s0", s0, last_sel);
        check("random final_busy", busy, 1'b0);
        check("random final_gate", ck_gate_en, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
